hv_classifier: RTL and testbench

Associative-memory classifier that sits directly downstream of the window encoder. It accepts one `window_hv` per handshake and computes the Hamming distance to each stored class prototype hypervector, CHUNK bits per cycle. It then reports the index of the nearest prototype (seizure / non-seizure) with its distances. Prototypes are loaded through a write port before inference.

---
 rtl/hv_classifier.sv | 143 ++++++++++++++
 tb/tb_hv_classifier.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_classifier.sv
// Hypervector associative-memory classifier: streams the query against every stored
// prototype CHUNK bits per cycle, then reports the nearest class and all distances.
`timescale 1ns/1ps
module hv_classifier #(
   parameter int DIMENSIONS  = 10000,
   parameter int NUM_CLASSES = 2,
   parameter int CHUNK       = 100,
   localparam int DW = $clog2(DIMENSIONS + 1),
   localparam int CW = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1
) (
   input  logic                      clk,
   input  logic                      nrst,
   input  logic                      proto_we,
   input  logic [CW-1:0]             proto_idx,
   input  logic [DIMENSIONS-1:0]     proto_hv,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIMENSIONS-1:0]     hv_in,
   output logic                      out_valid,
   output logic [CW-1:0]             class_out,
   output logic [DW-1:0]             min_dist,
   output logic [NUM_CLASSES*DW-1:0] dist_out
);

   localparam int NUM_CHUNKS = DIMENSIONS / CHUNK;
   localparam int CNTW       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [CNTW-1:0] LAST_CHUNK    = CNTW'(NUM_CHUNKS - 1);
   localparam logic [CW:0]     NUM_CLASSES_W = (CW + 1)'(NUM_CLASSES);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COMPARE = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;

   if (DIMENSIONS % CHUNK != 0) begin : g_chunk_check
      $error("hv_classifier: DIMENSIONS must be a multiple of CHUNK");
   end
   if (NUM_CLASSES < 2) begin : g_class_check
      $error("hv_classifier: NUM_CLASSES must be at least 2");
   end

   logic [1:0]            state_q, state_d;
   logic [CNTW-1:0]       cnt_q, cnt_d;
   logic [DIMENSIONS-1:0] query_q;
   logic [DIMENSIONS-1:0] proto_q [NUM_CLASSES];
   logic [DW-1:0]         acc_q [NUM_CLASSES];
   logic [DW-1:0]         acc_d [NUM_CLASSES];
   logic [DW-1:0]         chunk_dist [NUM_CLASSES];
   logic [31:0]           slice_base;

   logic                      out_valid_q;
   logic [CW-1:0]             class_q, best_idx;
   logic [DW-1:0]             min_q, best_dist;
   logic [NUM_CLASSES*DW-1:0] dist_q, dist_d;

   function automatic logic [DW-1:0] popcount(input logic [CHUNK-1:0] v);
      logic [DW-1:0] n;
      n = '0;
      for (int i = 0; i < CHUNK; i++) n = n + DW'(v[i]);
      return n;
   endfunction

   assign slice_base = 32'(cnt_q) * 32'(CHUNK);

   always_comb begin
      for (int k = 0; k < NUM_CLASSES; k++)
         chunk_dist[k] = popcount(query_q[slice_base +: CHUNK] ^ proto_q[k][slice_base +: CHUNK]);
   end

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_COMPARE;
               cnt_d   = '0;
               for (int k = 0; k < NUM_CLASSES; k++) acc_d[k] = '0;
            end
         end
         S_COMPARE: begin
            cnt_d = cnt_q + CNTW'(1);
            for (int k = 0; k < NUM_CLASSES; k++) acc_d[k] = acc_q[k] + chunk_dist[k];
            if (cnt_q == LAST_CHUNK) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Strict less-than keeps the lowest index on ties.
   always_comb begin
      best_idx  = '0;
      best_dist = acc_q[0];
      dist_d    = '0;
      for (int k = 1; k < NUM_CLASSES; k++) begin
         if (acc_q[k] < best_dist) begin
            best_idx  = CW'(k);
            best_dist = acc_q[k];
         end
      end
      for (int k = 0; k < NUM_CLASSES; k++) dist_d[k*DW +: DW] = acc_q[k];
   end

   // NOTE: sequential state uses non-blocking assignments only; the prototype store is
   // deliberately reset because a reset must leave every prototype at zero.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         query_q     <= '0;
         out_valid_q <= 1'b0;
         class_q     <= '0;
         min_q       <= '0;
         dist_q      <= '0;
         for (int k = 0; k < NUM_CLASSES; k++) begin
            proto_q[k] <= '0;
            acc_q[k]   <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         out_valid_q <= (state_q == S_DONE);
         if (state_q == S_IDLE && in_valid) query_q <= hv_in;
         if (state_q == S_IDLE && proto_we && ({1'b0, proto_idx} < NUM_CLASSES_W))
            proto_q[proto_idx] <= proto_hv;
         if (state_q == S_DONE) begin
            class_q <= best_idx;
            min_q   <= best_dist;
            dist_q  <= dist_d;
         end
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign class_out = class_q;
   assign min_dist  = min_q;
   assign dist_out  = dist_q;

endmodule

// File: tb/tb_hv_classifier.sv
// Bench for hv_classifier: default, 4-class/CHUNK=250 and 3-class/CHUNK=1000 instances,
// with a queue scoreboard per instance fed at stimulus time and drained on out_valid.
`timescale 1ns/1ps
module tb_hv_classifier;

   localparam int D  = 10000;
   localparam int DW = 14;

   typedef struct packed {
      logic [1:0]           cls;
      logic [DW-1:0]        mind;
      logic [7:0]           lat;
      logic [3:0][DW-1:0]   d;
   } exp_t;

   logic clk, nrst;
   logic [D-1:0] all1;

   logic pw0, iv0, ir0, ov0;
   logic [0:0] pidx0, cls0;
   logic [D-1:0] phv0, hv0;
   logic [DW-1:0] md0;
   logic [2*DW-1:0] do0;

   logic pw1, iv1, ir1, ov1;
   logic [1:0] pidx1, cls1;
   logic [D-1:0] phv1, hv1;
   logic [DW-1:0] md1;
   logic [4*DW-1:0] do1;

   logic pw2, iv2, ir2, ov2;
   logic [1:0] pidx2, cls2;
   logic [D-1:0] phv2, hv2;
   logic [DW-1:0] md2;
   logic [3*DW-1:0] do2;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   exp_t exp0[$], exp1[$], exp2[$];
   int acc0[$], acc1[$], acc2[$];
   int pulses0[$];
   logic [D-1:0] pm1 [4];
   logic [D-1:0] pm2 [4];

   hv_classifier u_dut0 (
      .clk(clk), .nrst(nrst), .proto_we(pw0), .proto_idx(pidx0), .proto_hv(phv0),
      .in_valid(iv0), .in_ready(ir0), .hv_in(hv0), .out_valid(ov0),
      .class_out(cls0), .min_dist(md0), .dist_out(do0));

   hv_classifier #(.NUM_CLASSES(4), .CHUNK(250)) u_dut1 (
      .clk(clk), .nrst(nrst), .proto_we(pw1), .proto_idx(pidx1), .proto_hv(phv1),
      .in_valid(iv1), .in_ready(ir1), .hv_in(hv1), .out_valid(ov1),
      .class_out(cls1), .min_dist(md1), .dist_out(do1));

   hv_classifier #(.NUM_CLASSES(3), .CHUNK(1000)) u_dut2 (
      .clk(clk), .nrst(nrst), .proto_we(pw2), .proto_idx(pidx2), .proto_hv(phv2),
      .in_valid(iv2), .in_ready(ir2), .hv_in(hv2), .out_valid(ov2),
      .class_out(cls2), .min_dist(md2), .dist_out(do2));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_result(input string tag, input exp_t e, input int lat,
                               input logic [1:0] cls, input logic [DW-1:0] md,
                               input logic [4*DW-1:0] d, input int nc);
      check({tag, "_latency"}, lat, e.lat);
      check({tag, "_class"}, cls, e.cls);
      check({tag, "_min_dist"}, md, e.mind);
      for (int k = 0; k < nc; k++)
         check($sformatf("%s_dist%0d", tag, k), d[k*DW +: DW], e.d[k]);
   endtask

   // Reference: plain popcount of XOR against each prototype, lowest index wins ties.
   function automatic exp_t mk_exp(input logic [D-1:0] hv, input logic [D-1:0] p [4],
                                   input int nc, input int lat);
      exp_t e;
      int best;
      e = '0;
      best = 0;
      for (int k = 0; k < nc; k++) e.d[k] = DW'($countones(hv ^ p[k]));
      for (int k = 1; k < nc; k++) if (e.d[k] < e.d[best]) best = k;
      e.cls  = 2'(best);
      e.mind = e.d[best];
      e.lat  = 8'(lat);
      return e;
   endfunction

   function automatic exp_t ex2(input int cls, input int md, input int d0, input int d1);
      exp_t e;
      e = '0;
      e.cls  = 2'(cls);
      e.mind = DW'(md);
      e.d[0] = DW'(d0);
      e.d[1] = DW'(d1);
      e.lat  = 8'd101;
      return e;
   endfunction

   function automatic logic [D-1:0] ones_low(input int n);
      logic [D-1:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [D-1:0] ones_high(input int n);
      logic [D-1:0] r;
      r = '0;
      for (int i = D - n; i < D; i++) r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [D-1:0] rand_hv();
      logic [D+31:0] t;
      t = '0;
      for (int i = 0; i < D; i += 32) t[i +: 32] = $urandom();
      return t[D-1:0];
   endfunction

   always @(negedge clk) begin : mon0
      exp_t e;
      int t;
      if (nrst && iv0 && ir0) acc0.push_back(cyc + 1);
      if (ov0) begin
         pulses0.push_back(cyc);
         if (exp0.size() == 0 || acc0.size() == 0) check("d0_spurious_out_valid", ov0, 1'b0);
         else begin
            e = exp0.pop_front();
            t = acc0.pop_front();
            check_result("d0", e, cyc - t, {1'b0, cls0}, md0, {{2*DW{1'b0}}, do0}, 2);
         end
      end
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      int t;
      if (nrst && iv1 && ir1) acc1.push_back(cyc + 1);
      if (ov1) begin
         if (exp1.size() == 0 || acc1.size() == 0) check("d1_spurious_out_valid", ov1, 1'b0);
         else begin
            e = exp1.pop_front();
            t = acc1.pop_front();
            check_result("d1", e, cyc - t, cls1, md1, do1, 4);
         end
      end
   end

   always @(negedge clk) begin : mon2
      exp_t e;
      int t;
      if (nrst && iv2 && ir2) acc2.push_back(cyc + 1);
      if (ov2) begin
         if (exp2.size() == 0 || acc2.size() == 0) check("d2_spurious_out_valid", ov2, 1'b0);
         else begin
            e = exp2.pop_front();
            t = acc2.pop_front();
            check_result("d2", e, cyc - t, cls2, md2, {{DW{1'b0}}, do2}, 3);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready0();
      int n = 0;
      while (!ir0 && n < 500) begin tick(); n++; end
      check("d0_ready_wait", ir0, 1'b1);
   endtask

   task automatic query0(input logic [D-1:0] hv, input exp_t e);
      wait_ready0();
      iv0 = 1'b1; hv0 = hv;
      exp0.push_back(e);
      tick();
      iv0 = 1'b0; hv0 = ~hv;
   endtask

   task automatic write0(input int idx, input logic [D-1:0] hv);
      pw0 = 1'b1; pidx0 = 1'(idx); phv0 = hv;
      tick();
      pw0 = 1'b0;
   endtask

   task automatic drain0();
      int n = 0;
      while (exp0.size() != 0 && n < 400) begin tick(); n++; end
      check("d0_drain", exp0.size(), 0);
   endtask

   task automatic query1(input logic [D-1:0] hv);
      int n = 0;
      while (!ir1 && n < 200) begin tick(); n++; end
      check("d1_ready_wait", ir1, 1'b1);
      iv1 = 1'b1; hv1 = hv;
      exp1.push_back(mk_exp(hv, pm1, 4, 41));
      tick();
      iv1 = 1'b0; hv1 = ~hv;
   endtask

   task automatic write1(input int idx, input logic [D-1:0] hv);
      pw1 = 1'b1; pidx1 = 2'(idx); phv1 = hv;
      pm1[idx] = hv;
      tick();
      pw1 = 1'b0;
   endtask

   task automatic drain1();
      int n = 0;
      while (exp1.size() != 0 && n < 200) begin tick(); n++; end
      check("d1_drain", exp1.size(), 0);
   endtask

   task automatic query2(input logic [D-1:0] hv);
      int n = 0;
      while (!ir2 && n < 100) begin tick(); n++; end
      check("d2_ready_wait", ir2, 1'b1);
      iv2 = 1'b1; hv2 = hv;
      exp2.push_back(mk_exp(hv, pm2, 3, 11));
      tick();
      iv2 = 1'b0; hv2 = ~hv;
   endtask

   task automatic write2(input int idx, input logic [D-1:0] hv);
      pw2 = 1'b1; pidx2 = 2'(idx); phv2 = hv;
      if (idx < 3) pm2[idx] = hv;
      tick();
      pw2 = 1'b0;
   endtask

   task automatic drain2();
      int n = 0;
      while (exp2.size() != 0 && n < 100) begin tick(); n++; end
      check("d2_drain", exp2.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "bench did not finish in time");
   end

   initial begin
      int n;
      all1 = '1;
      nrst = 1'b0;
      pw0 = 1'b0; pidx0 = '0; phv0 = '0; iv0 = 1'b0; hv0 = '0;
      pw1 = 1'b0; pidx1 = '0; phv1 = '0; iv1 = 1'b0; hv1 = '0;
      pw2 = 1'b0; pidx2 = '0; phv2 = '0; iv2 = 1'b0; hv2 = '0;
      for (int k = 0; k < 4; k++) begin pm1[k] = '0; pm2[k] = '0; end

      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
      check("rst_in_ready0", ir0, 1'b1);
      check("rst_out_valid0", ov0, 1'b0);
      check("rst_class0", cls0, 1'b0);
      check("rst_min_dist0", md0, 0);
      check("rst_dist_out0", do0, 0);
      check("rst_in_ready1", ir1, 1'b1);
      check("rst_in_ready2", ir2, 1'b1);

      // Basic distance and tie
      write0(0, '0);
      write0(1, all1);
      query0(ones_low(3000), ex2(0, 3000, 3000, 7000));
      drain0();
      query0(ones_high(5000), ex2(0, 5000, 5000, 5000));
      drain0();

      // Back-to-back with in_valid held; hv changes after the first accept
      iv0 = 1'b1; hv0 = all1;
      exp0.push_back(ex2(1, 0, 10000, 0));
      tick();
      hv0 = ones_low(3000);
      exp0.push_back(ex2(0, 3000, 3000, 7000));
      n = 0;
      while (!ov0 && n < 200) begin tick(); n++; end
      check("d0_b2b_first_pulse", ov0, 1'b1);
      tick();
      iv0 = 1'b0;
      drain0();
      n = pulses0.size();
      check("d0_pulse_count", n >= 2, 1'b1);
      if (n >= 2) check("d0_b2b_spacing", pulses0[n-1] - pulses0[n-2], 102);

      // Writes during COMPARE and DONE are ignored
      query0(all1, ex2(1, 0, 10000, 0));
      repeat (49) @(posedge clk);
      #1;
      pw0 = 1'b1; pidx0 = 1'b1; phv0 = '0;
      tick();
      pw0 = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      pw0 = 1'b1;
      tick();
      pw0 = 1'b0;
      drain0();
      query0(all1, ex2(1, 0, 10000, 0));
      drain0();

      // Write concurrent with accept takes effect for that query
      wait_ready0();
      pw0 = 1'b1; pidx0 = 1'b1; phv0 = '0;
      iv0 = 1'b1; hv0 = all1;
      exp0.push_back(ex2(0, 10000, 10000, 10000));
      tick();
      pw0 = 1'b0; iv0 = 1'b0;
      drain0();

      // Reset mid-compare aborts the query and clears prototypes and results
      write0(1, all1);
      query0(ones_low(3000), ex2(0, 3000, 3000, 7000));
      repeat (49) @(posedge clk);
      #1;
      nrst = 1'b0;
      tick();
      nrst = 1'b1;
      exp0.delete();
      acc0.delete();
      check("midrst_in_ready", ir0, 1'b1);
      check("midrst_out_valid", ov0, 1'b0);
      check("midrst_class", cls0, 1'b0);
      check("midrst_min_dist", md0, 0);
      check("midrst_dist_out", do0, 0);
      n = pulses0.size();
      repeat (150) @(posedge clk);
      #1;
      check("midrst_no_pulse", pulses0.size(), n);
      query0(ones_low(3000), ex2(0, 3000, 3000, 3000));
      drain0();

      // Three-class instance: out-of-range index ignored, class 2 reachable
      write2(3, all1);
      query2(all1);
      drain2();
      write2(2, all1);
      query2(all1);
      drain2();
      for (int k = 0; k < 3; k++) write2(k, rand_hv());
      query2(rand_hv());
      drain2();

      // Four-class random regression, prototypes reloaded every 25 queries
      for (int i = 0; i < 200; i++) begin
         if (i % 25 == 0) begin
            drain1();
            for (int k = 0; k < 4; k++) write1(k, rand_hv());
         end
         query1(rand_hv());
      end
      drain1();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
